// File: rtl/taillight_monitor.sv
`default_nettype none
// ============================================================================
// Module      : taillight_monitor
// Description : Receiving end of the taillight interface. Samples the 3-bit
//               taillight pattern every clock, decodes it into OFF / BRAKE /
//               TURN / FAULT, tracks the turn-blink phase, counts completed
//               blink sequences and flags illegal patterns, bad orderings and
//               stuck blinkers. All outputs are registered (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module taillight_monitor #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       taillights,
    input  logic             clear_fault,
    output logic [1:0]       mode,
    output logic [1:0]       turn_phase,
    output logic             seq_done,
    output logic [CNT_W-1:0] seq_count,
    output logic             fault,
    output logic [1:0]       fault_code
);

    // Hold counter must reach MAX_HOLD+1 (the saturation / violation value).
    localparam int                  c_hold_w   = $clog2(MAX_HOLD + 2);
    localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD + 1);

    // Pattern encodings.
    localparam logic [2:0] c_pat_000 = 3'b000;
    localparam logic [2:0] c_pat_001 = 3'b001;
    localparam logic [2:0] c_pat_011 = 3'b011;
    localparam logic [2:0] c_pat_111 = 3'b111;

    // Mode and fault-code encodings.
    localparam logic [1:0] c_mode_off   = 2'b00;
    localparam logic [1:0] c_mode_brake = 2'b01;
    localparam logic [1:0] c_mode_turn  = 2'b10;
    localparam logic [1:0] c_mode_fault = 2'b11;

    localparam logic [1:0] c_code_none    = 2'b00;
    localparam logic [1:0] c_code_illegal = 2'b01;
    localparam logic [1:0] c_code_order   = 2'b10;
    localparam logic [1:0] c_code_stuck   = 2'b11;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_BRAKE = 3'd1,
        ST_TURN0 = 3'd2,
        ST_TURN1 = 3'd3,
        ST_TURN2 = 3'd4,
        ST_TURN3 = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_prev;
    logic [c_hold_w-1:0] r_hold;
    logic [c_hold_w-1:0] w_hold_next;
    logic                w_hold_viol;
    logic                w_same;
    logic                w_illegal;
    logic                w_clear;
    logic                w_seq_pulse;
    logic [1:0]          w_code_next;
    logic [1:0]          w_mode_next;
    logic [1:0]          w_phase_next;

    logic [1:0]          r_mode;
    logic [1:0]          r_turn_phase;
    logic                r_seq_done;
    logic [CNT_W-1:0]    r_seq_count;
    logic                r_fault;
    logic [1:0]          r_fault_code;

    // Hold tracking: reload on a change of pattern, otherwise count up and
    // saturate at MAX_HOLD+1; reaching that value is a hold violation.
    always_comb begin
        w_same      = (taillights == r_prev);
        w_hold_next = c_hold_one;
        if (w_same) begin
            w_hold_next = (r_hold == c_hold_max) ? r_hold : (r_hold + c_hold_one);
        end
        w_hold_viol = (w_hold_next == c_hold_max);
        w_illegal   = (taillights != c_pat_000) && (taillights != c_pat_001) &&
                      (taillights != c_pat_011) && (taillights != c_pat_111);
    end

    // Next-state decode: pattern rules when not faulted, clear handling when
    // faulted. A "hold" keeps the current state unless the hold limit trips.
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_fault_code;
        w_seq_pulse  = 1'b0;
        w_clear      = 1'b0;

        if (r_state == ST_FAULT) begin
            // Decode context is lost while faulted, so only a pattern that is
            // illegal on its own can count as a fault coinciding with clear.
            if (clear_fault) begin
                if (w_illegal) begin
                    w_code_next = c_code_illegal;
                end else begin
                    w_state_next = ST_OFF;
                    w_code_next  = c_code_none;
                    w_clear      = 1'b1;
                end
            end
        end else begin
            case (taillights)
                c_pat_001: begin
                    if ((r_prev == c_pat_000) || (r_prev == c_pat_111)) begin
                        w_state_next = ST_TURN0;
                    end else if (r_prev == c_pat_001) begin
                        if (w_hold_viol) begin
                            w_state_next = ST_FAULT;
                            w_code_next  = c_code_stuck;
                        end
                    end else begin
                        w_state_next = ST_FAULT;
                        w_code_next  = c_code_order;
                    end
                end
                c_pat_011: begin
                    if ((r_prev == c_pat_001) && (r_state == ST_TURN0)) begin
                        w_state_next = ST_TURN1;
                    end else if (r_prev == c_pat_011) begin
                        if (w_hold_viol) begin
                            w_state_next = ST_FAULT;
                            w_code_next  = c_code_stuck;
                        end
                    end else begin
                        w_state_next = ST_FAULT;
                        w_code_next  = c_code_order;
                    end
                end
                c_pat_111: begin
                    if ((r_state == ST_TURN1) && (r_prev == c_pat_011)) begin
                        w_state_next = ST_TURN2;
                    end else if ((r_state == ST_TURN2) && w_same) begin
                        // Full-on held too long: turn released while braking.
                        if (w_hold_viol) begin
                            w_state_next = ST_BRAKE;
                        end
                    end else begin
                        w_state_next = ST_BRAKE;
                    end
                end
                c_pat_000: begin
                    if (r_state == ST_TURN2) begin
                        w_state_next = ST_TURN3;
                        w_seq_pulse  = 1'b1;
                    end else if (r_state == ST_TURN3) begin
                        // Dark gap held too long: blinker has stopped.
                        if (w_hold_viol) begin
                            w_state_next = ST_OFF;
                        end
                    end else begin
                        w_state_next = ST_OFF;
                    end
                end
                default: begin
                    w_state_next = ST_FAULT;
                    w_code_next  = c_code_illegal;
                end
            endcase
        end
    end

    // Output encoding of the next state, registered alongside it.
    always_comb begin
        w_mode_next  = c_mode_off;
        w_phase_next = 2'd0;
        case (w_state_next)
            ST_BRAKE: w_mode_next = c_mode_brake;
            ST_TURN0: begin w_mode_next = c_mode_turn; w_phase_next = 2'd0; end
            ST_TURN1: begin w_mode_next = c_mode_turn; w_phase_next = 2'd1; end
            ST_TURN2: begin w_mode_next = c_mode_turn; w_phase_next = 2'd2; end
            ST_TURN3: begin w_mode_next = c_mode_turn; w_phase_next = 2'd3; end
            ST_FAULT: w_mode_next = c_mode_fault;
            default:  w_mode_next = c_mode_off;
        endcase
    end

    // State, sample history, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_OFF;
            r_prev       <= c_pat_000;
            r_hold       <= '0;
            r_mode       <= c_mode_off;
            r_turn_phase <= 2'd0;
            r_seq_done   <= 1'b0;
            r_seq_count  <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= c_code_none;
        end else begin
            r_state      <= w_state_next;
            // A successful clear restarts decoding as if the last sample was 000.
            r_prev       <= w_clear ? c_pat_000 : taillights;
            r_hold       <= w_clear ? '0 : w_hold_next;
            r_mode       <= w_mode_next;
            r_turn_phase <= w_phase_next;
            r_seq_done   <= w_seq_pulse;
            r_fault      <= (w_state_next == ST_FAULT);
            r_fault_code <= w_code_next;
            if (w_seq_pulse && (r_seq_count != {CNT_W{1'b1}})) begin
                r_seq_count <= r_seq_count + 1'b1;
            end
        end
    end

    assign mode       = r_mode;
    assign turn_phase = r_turn_phase;
    assign seq_done   = r_seq_done;
    assign seq_count  = r_seq_count;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_taillight_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_taillight_monitor
// Description : Directed self-checking bench for taillight_monitor. A second
//               instance with a 2-bit counter exercises count saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taillight_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] taillights;
    logic       clear_fault;

    logic [1:0] mode, turn_phase, fault_code;
    logic       seq_done, fault;
    logic [7:0] seq_count;

    logic [1:0] mode2, turn_phase2, fault_code2;
    logic       seq_done2, fault2;
    logic [1:0] seq_count2;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] pat [4];

    taillight_monitor #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .taillights(taillights), .clear_fault(clear_fault),
        .mode(mode), .turn_phase(turn_phase), .seq_done(seq_done),
        .seq_count(seq_count), .fault(fault), .fault_code(fault_code)
    );

    taillight_monitor #(.MAX_HOLD(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .taillights(taillights), .clear_fault(clear_fault),
        .mode(mode2), .turn_phase(turn_phase2), .seq_done(seq_done2),
        .seq_count(seq_count2), .fault(fault2), .fault_code(fault_code2)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] m, input logic [1:0] ph,
                             input logic sd, input logic f, input logic [1:0] code);
        check({tag, "_mode"},  32'(mode),       32'(m));
        check({tag, "_phase"}, 32'(turn_phase), 32'(ph));
        check({tag, "_done"},  32'(seq_done),   32'(sd));
        check({tag, "_fault"}, 32'(fault),      32'(f));
        check({tag, "_code"},  32'(fault_code), 32'(code));
    endtask

    // Apply one sample, clock it in, then settle past the edge.
    task automatic step(input logic [2:0] t, input logic clr);
        taillights  = t;
        clear_fault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3'b000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        pat[0] = 3'b001; pat[1] = 3'b011; pat[2] = 3'b111; pat[3] = 3'b000;
        reset = 1'b1; taillights = 3'b000; clear_fault = 1'b0;

        // Reset state.
        do_reset();
        check_all("rst", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        check("rst_count", 32'(seq_count), 0);

        // Idle 000 for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            step(3'b000, 1'b0);
            check("idle_mode", 32'(mode), 0);
            check("idle_fault", 32'(fault), 0);
        end
        check("idle_count", 32'(seq_count), 0);

        // Three full blink sequences, each pattern held 4 cycles.
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) begin
                for (int j = 0; j < 4; j++) begin
                    step(pat[p], 1'b0);
                    check("seq_mode", 32'(mode), 2);
                    check("seq_phase", 32'(turn_phase), 32'(p));
                    check("seq_done", 32'(seq_done), (p == 3 && j == 0) ? 1 : 0);
                    if (p == 3 && j == 0) check("seq_cnt", 32'(seq_count), 32'(r + 1));
                end
            end
        end
        check("seq_count3", 32'(seq_count), 3);

        // Dark gap held: 8 total cycles stays in phase 3, the 9th drops to OFF.
        for (int i = 0; i < 4; i++) begin
            step(3'b000, 1'b0);
            check_all("gap", 2'd2, 2'd3, 1'b0, 1'b0, 2'd0);
        end
        step(3'b000, 1'b0);
        check_all("gap_off", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);

        // Brake: 111 for 10 cycles then back to 000.
        for (int i = 0; i < 10; i++) begin
            step(3'b111, 1'b0);
            check_all("brake", 2'd1, 2'd0, 1'b0, 1'b0, 2'd0);
        end
        step(3'b000, 1'b0);
        check_all("brake_off", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        check("brake_count", 32'(seq_count), 3);

        // Mid-turn: 111 held at phase 2 trips to BRAKE on the 9th cycle.
        step(3'b001, 1'b0);
        check_all("mid_p0", 2'd2, 2'd0, 1'b0, 1'b0, 2'd0);
        step(3'b011, 1'b0);
        check_all("mid_p1", 2'd2, 2'd1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            step(3'b111, 1'b0);
            check_all("mid_p2", 2'd2, 2'd2, 1'b0, 1'b0, 2'd0);
        end
        step(3'b111, 1'b0);
        check_all("mid_rel", 2'd1, 2'd0, 1'b0, 1'b0, 2'd0);
        step(3'b000, 1'b0);
        check_all("mid_off", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);

        // Stuck 001: 8 cycles holds, the 9th faults with code 11.
        for (int i = 0; i < 8; i++) begin
            step(3'b001, 1'b0);
            check_all("stuck_hold", 2'd2, 2'd0, 1'b0, 1'b0, 2'd0);
        end
        step(3'b001, 1'b0);
        check_all("stuck", 2'd3, 2'd0, 1'b0, 1'b1, 2'd3);
        step(3'b000, 1'b0);
        check_all("stuck_sticky", 2'd3, 2'd0, 1'b0, 1'b1, 2'd3);
        check("stuck_count", 32'(seq_count), 3);

        // Clear, then illegal 101.
        step(3'b000, 1'b1);
        check_all("clr1", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        step(3'b101, 1'b0);
        check_all("illegal", 2'd3, 2'd0, 1'b0, 1'b1, 2'd1);
        step(3'b000, 1'b1);
        check_all("clr2", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);

        // 000 -> 011 is a bad order.
        step(3'b000, 1'b0);
        check_all("pre_order", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        step(3'b011, 1'b0);
        check_all("order", 2'd3, 2'd0, 1'b0, 1'b1, 2'd2);

        // Clear coinciding with an illegal pattern: fault wins with code 01.
        step(3'b010, 1'b1);
        check_all("clr_vs_ill", 2'd3, 2'd0, 1'b0, 1'b1, 2'd1);

        // Clear while 011 is present; the next 011 is judged with prev=000.
        step(3'b011, 1'b1);
        check_all("clr3", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        step(3'b011, 1'b0);
        check_all("post_clr", 2'd3, 2'd0, 1'b0, 1'b1, 2'd2);
        step(3'b000, 1'b1);
        check_all("clr4", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);

        // clear_fault outside FAULT has no effect.
        step(3'b001, 1'b1);
        check_all("clr_noop", 2'd2, 2'd0, 1'b0, 1'b0, 2'd0);
        step(3'b011, 1'b0);
        check_all("pre_rst", 2'd2, 2'd1, 1'b0, 1'b0, 2'd0);

        // Reset mid-sequence, then 111 is judged with prev=000 -> BRAKE.
        reset = 1'b1;
        step(3'b111, 1'b0);
        reset = 1'b0;
        check_all("mid_rst", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        check("mid_rst_count", 32'(seq_count), 0);
        step(3'b111, 1'b0);
        check_all("rst_brake", 2'd1, 2'd0, 1'b0, 1'b0, 2'd0);

        // Reset, then 011 is judged with prev=000 -> bad order.
        do_reset();
        step(3'b011, 1'b0);
        check_all("rst_order", 2'd3, 2'd0, 1'b0, 1'b1, 2'd2);

        // Counter saturation on the 2-bit instance.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            for (int p = 0; p < 4; p++) step(pat[p], 1'b0);
            check("sat_done", 32'(seq_done2), 1);
            check("sat_cnt2", 32'(seq_count2), (k > 3) ? 3 : 32'(k));
            check("sat_cnt8", 32'(seq_count), 32'(k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
